// File: rtl/dot_scroll_sched.sv
// dot_scroll_sched: scrolls a 5-column window of a message buffer into a 5x7 matrix controller
module dot_scroll_sched #(
  parameter int MSG_LEN    = 16,
  parameter int SCROLL_DIV = 1000
) (
  input  logic       colclk,
  input  logic       reset,
  input  logic       enable_i,
  input  logic       run_i,
  input  logic       load_valid_i,
  output logic       load_ready_o,
  input  logic [4:0] load_addr_i,
  input  logic [6:0] load_data_i,
  output logic       wr_en_o,
  output logic [4:0] wr_col_o,
  output logic [6:0] wr_data_o,
  output logic       frame_done_o,
  output logic [4:0] scroll_pos_o
);
  localparam int AW = $clog2(MSG_LEN);
  localparam int DW = SCROLL_DIV > 1 ? $clog2(SCROLL_DIV) : 1;
  typedef enum logic [1:0] {IDLE, PUSH, WAIT} state_t;
  state_t          state_q;
  logic [2:0]      k_q;
  logic [4:0]      offset_q;
  logic [DW-1:0]   div_q;
  logic [6:0]      buf_q [MSG_LEN];
  logic            wr_en_q, fd_q, ready_q;
  logic [4:0]      wr_col_q;
  logic [6:0]      wr_data_q;
  logic            load_fire, load_in_range, load_hit, go_push;
  logic [2:0]      rd_k;
  logic [5:0]      rd_sum, rd_idx;
  logic [6:0]      rd_data;
  logic [4:0]      offset_inc;
  // Freezing gates the strobes combinationally so they drop in the same cycle enable falls.
  assign wr_en_o      = wr_en_q & enable_i;
  assign load_ready_o = ready_q & enable_i;
  assign frame_done_o = fd_q & enable_i;
  assign wr_col_o     = wr_col_q;
  assign wr_data_o    = wr_data_q;
  assign scroll_pos_o = offset_q;
  // Next column to fetch; a load landing on the same edge is forwarded so it is never missed.
  always_comb begin
    load_fire     = load_valid_i & load_ready_o;
    load_in_range = {1'b0, load_addr_i} < 6'(MSG_LEN);
    go_push       = run_i && (state_q == IDLE || (state_q == WAIT && div_q == '0));
    rd_k          = (state_q == PUSH) ? k_q + 3'd1 : 3'd0;
    rd_sum        = {1'b0, offset_q} + {3'b0, rd_k};
    rd_idx        = (rd_sum >= 6'(MSG_LEN)) ? rd_sum - 6'(MSG_LEN) : rd_sum;
    load_hit      = load_fire && ({1'b0, load_addr_i} == rd_idx);
    rd_data       = load_hit ? load_data_i : buf_q[rd_idx[AW-1:0]];
    offset_inc    = (offset_q == 5'(MSG_LEN - 1)) ? 5'd0 : offset_q + 5'd1;
  end
  // Scheduler FSM with registered write port, buffer loads and frame pacing.
  always_ff @(posedge colclk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      offset_q  <= '0;
      div_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_col_q  <= '0;
      wr_data_q <= '0;
      fd_q      <= 1'b0;
      ready_q   <= 1'b1;
      for (int i = 0; i < MSG_LEN; i++) buf_q[i] <= '0;
    end else if (!enable_i) begin
      fd_q <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      if (load_fire && load_in_range) buf_q[load_addr_i[AW-1:0]] <= load_data_i;
      if (go_push) begin
        state_q   <= PUSH;
        k_q       <= '0;
        wr_en_q   <= 1'b1;
        wr_col_q  <= '0;
        wr_data_q <= rd_data;
        ready_q   <= 1'b0;
      end else if (state_q == PUSH && k_q == 3'd4) begin
        state_q  <= WAIT;
        wr_en_q  <= 1'b0;
        fd_q     <= 1'b1;
        offset_q <= offset_inc;
        div_q    <= DW'(SCROLL_DIV - 1);
        ready_q  <= 1'b1;
      end else if (state_q == PUSH) begin
        k_q       <= rd_k;
        wr_col_q  <= 5'(rd_k);
        wr_data_q <= rd_data;
      end else if (state_q == WAIT && div_q == '0) begin
        state_q  <= IDLE;
        offset_q <= '0;
      end else if (state_q == WAIT) begin
        div_q <= div_q - 1'b1;
      end
    end
  end
endmodule
